branch_unit: RTL and testbench
==============================

# branch_unit

Resolves conditional and register branches in the decode stage by consuming the 3-bit flag vector held in the flag register, i.e. it is the direct downstream consumer of that register's `flag_out`. The block evaluates the 3-bit condition code against the flags, computes the branch target, and issues a registered one-cycle redirect to the fetch stage. It detects the flag read-after-write hazard, where a flag-writing instruction is in EX, and stalls decode for exactly one cycle until the flag register has committed.

## Interface
Parameters:
- `ADDR_W`, 16: PC / target width.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `br_valid` input 1: a branch instruction is present in decode this cycle.
- `br_type` input 1: 0 = B (PC-relative immediate), 1 = BR (register target).
- `ccc` input 3: condition code from the instruction.
- `pc_plus2` input ADDR_W: address of the branch plus 2.
- `imm9` input 9: signed word offset (B only).
- `rs_data` input ADDR_W: register target (BR only).
- `flag_out` input 3: committed flags from the flag register; bit2 = N, bit1 = V, bit0 = Z.
- `flag_wr_pend` input 1: the instruction in EX writes at least one flag at the end of this cycle (OR of the flag register's `en`).
- `flush` input 1: synchronous cancel of any branch being accepted or held.
- `stall_out` output 1: freeze decode/fetch this cycle (combinational).
- `redirect` output 1: registered pulse; branch taken, load `target` into PC.
- `resolved` output 1: registered pulse; a branch finished evaluation, taken or not.
- `target` output ADDR_W: registered branch target, valid while `redirect` = 1.

## Operation
- Conditions:
  - 000 NE: Z = 0.
  - 001 EQ: Z = 1.
  - 010 GT: Z = 0 and N = 0.
  - 011 LT: N = 1.
  - 100 GE: Z = 1, or Z = 0 and N = 0.
  - 101 LE: N = 1 or Z = 1.
  - 110 OV: V = 1.
  - 111 always.
- Targets:
  - B: `target` = `pc_plus2` + (sign_ext(`imm9`) << 1), truncated to ADDR_W. Wrap-around modulo 2^16 is required; 0xFFFE + 4 → 0x0002.
  - BR: `target` = `rs_data`, unmodified.
- Hazard: `br_valid` & `flag_wr_pend` & (`ccc` ≠ 111). An unconditional branch never stalls.
- FSM states: IDLE, HOLD.
  - IDLE, no `br_valid`: stay IDLE, outputs pulse low.
  - IDLE, `br_valid` with no hazard: evaluate with current `flag_out`, register `redirect`/`resolved`/`target`, stay IDLE. Back-to-back branches are accepted every cycle.
  - IDLE, `br_valid` with hazard: `stall_out` = 1, go to HOLD. Nothing is registered.
  - HOLD: `stall_out` = 1 and `flag_out` now reflects the committed write. Evaluate, register results, return to IDLE. `flag_wr_pend` is ignored in HOLD.
- Handshake: while `stall_out` = 1, upstream holds `br_valid` and all branch fields stable.
- Flush:
  - `flush` = 1 in IDLE or HOLD: next state IDLE, and no `redirect`/`resolved` is produced for that branch.
  - A pulse already visible in the flush cycle is unaffected.
  - `flush` has priority over `br_valid`.
- Reset (any time, including in HOLD): state = IDLE, `redirect` = 0, `resolved` = 0, `target` = 0, `stall_out` = 0.

## Timing
- No-hazard latency: `br_valid` in cycle t → `resolved`/`redirect` high in t+1, for exactly one cycle.
- Hazard latency: `br_valid` in t with `stall_out` high in t and t+1 → pulses in t+2.
- `stall_out` is never high for more than 2 consecutive cycles per branch.
- `redirect` implies `resolved`. `resolved` without `redirect` means not taken, and `target` then holds its previous value.

## Structure
- Shared package `wisc_pkg`:
  - ccc encodings (CC_NE … CC_UNCOND).
  - Flag bit indices (FLAG_Z = 0, FLAG_V = 1, FLAG_N = 2).
  - FSM state encoding (IDLE, HOLD).
- Sub-module `branch_cond`: purely combinational (`ccc`, flags) → `take`. Instantiated once.
- Target adder and FSM live in `branch_unit`.

## Test plan
- Reset: hold `rst` = 0 mid-HOLD → `stall_out` = 0 and `redirect`/`resolved`/`target` = 0 while `rst` is low; IDLE after release.
- No hazard, B EQ:
  - `flag_out` = 001, `imm9` = 0x004, `pc_plus2` = 0x0010 → next cycle `redirect` = 1, `target` = 0x0018.
  - Same with `flag_out` = 000 → `resolved` = 1, `redirect` = 0.
- Hazard, B LT:
  - `flag_out` = 000 and `flag_wr_pend` = 1 in cycle t; `flag_out` becomes 100 in t+1.
  - Required: `stall_out` high in t and t+1; `redirect` in t+2.
- Unconditional BR with `flag_wr_pend` = 1, `rs_data` = 0xBEEF → no stall, `redirect` in t+1, `target` = 0xBEEF.
- Wrap and sign:
  - `pc_plus2` = 0xFFFE, `imm9` = 0x002 → `target` 0x0002.
  - `pc_plus2` = 0x0004, `imm9` = 0x1FE (−2) → `target` 0x0000.
- Flush in HOLD → no `resolved`/`redirect` in the following cycle. A back-to-back pair of not-taken then taken branches → `resolved` in consecutive cycles, `redirect` only on the second.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared definitions for the branch resolution path.
// Condition codes, flag bit positions and branch FSM states.
package wisc_pkg;

  typedef enum logic [2:0] {
    CC_NE     = 3'b000,
    CC_EQ     = 3'b001,
    CC_GT     = 3'b010,
    CC_LT     = 3'b011,
    CC_GE     = 3'b100,
    CC_LE     = 3'b101,
    CC_OV     = 3'b110,
    CC_UNCOND = 3'b111
  } ccc_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } br_state_e;

endpackage

// File: rtl/branch_cond.sv
// Condition-code evaluator: decides whether a branch is taken
// from the instruction's ccc and the committed N/V/Z flags.
module branch_cond
  import wisc_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [2:0] flags,
  output logic       take
);

  logic z;
  logic v;
  logic n;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  always_comb begin
    take = 1'b0;
    unique case (ccc_e'(ccc))
      CC_NE:     take = ~z;
      CC_EQ:     take = z;
      CC_GT:     take = ~z & ~n;
      CC_LT:     take = n;
      CC_GE:     take = z | ~n;
      CC_LE:     take = n | z;
      CC_OV:     take = v;
      CC_UNCOND: take = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Decode-stage branch resolver: condition check, target adder,
// one-cycle flag hazard stall and registered redirect to fetch.
module branch_unit
  import wisc_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  input  logic              br_type,
  input  logic [2:0]        ccc,
  input  logic [ADDR_W-1:0] pc_plus2,
  input  logic [8:0]        imm9,
  input  logic [ADDR_W-1:0] rs_data,
  input  logic [2:0]        flag_out,
  input  logic              flag_wr_pend,
  input  logic              flush,
  output logic              stall_out,
  output logic              redirect,
  output logic              resolved,
  output logic [ADDR_W-1:0] target
);

  br_state_e         state_q, state_d;
  logic              hazard;
  logic              take;
  logic              eval;
  logic              stall_raw;
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] calc;
  logic              redirect_q, redirect_d;
  logic              resolved_q, resolved_d;
  logic [ADDR_W-1:0] target_q, target_d;

  branch_cond u_cond (
    .ccc   (ccc),
    .flags (flag_out),
    .take  (take)
  );

  assign hazard = br_valid & flag_wr_pend
                & (ccc != CC_UNCOND);

  // Word offset: sign-extend and scale by two bytes.
  assign off  = {{(ADDR_W-10){imm9[8]}}, imm9, 1'b0};
  assign calc = br_type ? rs_data : pc_plus2 + off;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (br_valid && hazard && !flush) state_d = HOLD;
      HOLD: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_raw = 1'b0;
    eval      = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_raw = hazard;
        eval      = br_valid & ~hazard & ~flush;
      end
      HOLD: begin
        stall_raw = 1'b1;
        eval      = ~flush;
      end
    endcase
  end

  // Stall must read low while reset is held, even mid-hazard.
  assign stall_out = stall_raw & rst;

  always_comb begin
    resolved_d = eval;
    redirect_d = eval & take;
    target_d   = (eval & take) ? calc : target_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_q <= 1'b0;
      resolved_q <= 1'b0;
      target_q   <= '0;
    end else begin
      redirect_q <= redirect_d;
      resolved_q <= resolved_d;
      target_q   <= target_d;
    end
  end

  assign redirect = redirect_q;
  assign resolved = resolved_q;
  assign target   = target_q;

endmodule

// File: tb/tb_branch_unit.sv
// Randomized scoreboard bench for branch_unit.
// Reference model works on whole branch transactions.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_type = 1'b0;
  logic [2:0]  ccc = '0;
  logic [15:0] pc_plus2 = '0;
  logic [8:0]  imm9 = '0;
  logic [15:0] rs_data = '0;
  logic [2:0]  flag_out = '0;
  logic        flag_wr_pend = 1'b0;
  logic        flush = 1'b0;
  logic        stall_out;
  logic        redirect;
  logic        resolved;
  logic [15:0] target;

  branch_unit #(.ADDR_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .br_valid     (br_valid),
    .br_type      (br_type),
    .ccc          (ccc),
    .pc_plus2     (pc_plus2),
    .imm9         (imm9),
    .rs_data      (rs_data),
    .flag_out     (flag_out),
    .flag_wr_pend (flag_wr_pend),
    .flush        (flush),
    .stall_out    (stall_out),
    .redirect     (redirect),
    .resolved     (resolved),
    .target       (target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic [15:0] tgt;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] last_tgt = '0;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Branch conditions as stated on N/V/Z.
  function automatic logic cond_ok(input logic [2:0] c,
                                   input logic [2:0] f);
    logic n;
    logic v;
    logic z;
    n = f[2];
    v = f[1];
    z = f[0];
    case (c)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || (!z && !n);
      3'd5:    return n || z;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] b_target(input logic [15:0] pc,
                                           input logic [8:0] im);
    int p;
    int o;
    p = int'(pc);
    o = int'($signed(im));
    return 16'((p + 2 * o) % 65536);
  endfunction

  task automatic expect_result(input logic tk,
                               input logic [15:0] tgt);
    exp_t e;
    e.taken = tk;
    if (tk) last_tgt = tgt;
    e.tgt = last_tgt;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per resolved pulse.
  always @(negedge clk) begin
    if (resolved === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resolved: got resolved=1 want 0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (redirect !== e.taken || target !== e.tgt) begin
          errors++;
          $display("FAIL result: got redirect=%0b target=%0h want redirect=%0b target=%0h",
                   redirect, target, e.taken, e.tgt);
        end
      end
    end else if (redirect !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL redirect_no_resolved: got redirect=%0b want 0", redirect);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      br_valid     = 1'b0;
      flush        = 1'b0;
      flag_wr_pend = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_stall", 16'(stall_out), 16'd0);
    end
  endtask

  // fl_at: 0 none, 1 flush on accept cycle, 2 flush in hold cycle.
  task automatic branch(input logic bt, input logic [2:0] c,
                        input logic [15:0] pc, input logic [8:0] im,
                        input logic [15:0] rs, input logic [2:0] f0,
                        input logic [2:0] f1, input logic pend,
                        input int fl_at);
    logic        haz;
    logic [15:0] tgt;
    haz = pend && (c != 3'b111);
    tgt = bt ? rs : b_target(pc, im);
    @(posedge clk);
    #1;
    br_valid     = 1'b1;
    br_type      = bt;
    ccc          = c;
    pc_plus2     = pc;
    imm9         = im;
    rs_data      = rs;
    flag_out     = f0;
    flag_wr_pend = pend;
    flush        = (fl_at == 1);
    @(negedge clk);
    chk("stall_first", 16'(stall_out), 16'(haz));
    if (!haz) begin
      if (fl_at != 1) expect_result(cond_ok(c, f0), tgt);
    end else begin
      @(posedge clk);
      #1;
      flag_out     = f1;
      flag_wr_pend = 1'($urandom_range(0, 1));
      flush        = (fl_at == 2);
      @(negedge clk);
      chk("stall_hold", 16'(stall_out), 16'd1);
      if (fl_at != 2) expect_result(cond_ok(c, f1), tgt);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_stall", 16'(stall_out), 16'd0);
    chk("rst_redirect", 16'(redirect), 16'd0);
    chk("rst_resolved", 16'(resolved), 16'd0);
    chk("rst_target", target, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // B EQ taken, then not taken.
    branch(1'b0, 3'd1, 16'h0010, 9'h004, 16'h0, 3'b001, 3'b000, 1'b0, 0);
    branch(1'b0, 3'd1, 16'h0010, 9'h004, 16'h0, 3'b000, 3'b000, 1'b0, 0);
    idle(1);

    // Reset asserted while holding on a hazard.
    @(posedge clk);
    #1;
    br_valid     = 1'b1;
    br_type      = 1'b0;
    ccc          = 3'd3;
    flag_out     = 3'b000;
    flag_wr_pend = 1'b1;
    flush        = 1'b0;
    @(negedge clk);
    chk("pre_rst_stall", 16'(stall_out), 16'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("hold_rst_stall", 16'(stall_out), 16'd0);
    chk("hold_rst_redirect", 16'(redirect), 16'd0);
    chk("hold_rst_resolved", 16'(resolved), 16'd0);
    chk("hold_rst_target", target, 16'd0);
    @(negedge clk);
    chk("hold_rst_stall2", 16'(stall_out), 16'd0);
    chk("hold_rst_target2", target, 16'd0);
    last_tgt = '0;
    @(posedge clk);
    #1;
    br_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", 16'(stall_out), 16'd0);

    // Hazard on LT, flags commit N during hold.
    branch(1'b0, 3'd3, 16'h0100, 9'h010, 16'h0, 3'b000, 3'b100, 1'b1, 0);
    // Unconditional BR never stalls.
    branch(1'b1, 3'd7, 16'h0000, 9'h000, 16'hBEEF, 3'b000, 3'b000, 1'b1, 0);
    // Wrap-around and negative offset.
    branch(1'b0, 3'd7, 16'hFFFE, 9'h002, 16'h0, 3'b000, 3'b000, 1'b0, 0);
    branch(1'b0, 3'd7, 16'h0004, 9'h1FE, 16'h0, 3'b000, 3'b000, 1'b0, 0);
    // Flush in hold, flush on accept.
    branch(1'b0, 3'd3, 16'h0200, 9'h003, 16'h0, 3'b000, 3'b100, 1'b1, 2);
    branch(1'b0, 3'd7, 16'h0300, 9'h003, 16'h0, 3'b000, 3'b000, 1'b0, 1);
    // Back-to-back not taken then taken.
    branch(1'b0, 3'd0, 16'h0400, 9'h008, 16'h0, 3'b001, 3'b000, 1'b0, 0);
    branch(1'b0, 3'd1, 16'h0500, 9'h008, 16'h0, 3'b001, 3'b000, 1'b0, 0);
    idle(2);

    for (int i = 0; i < 300; i++) begin
      logic        bt;
      logic [2:0]  c;
      logic        pend;
      logic        haz;
      int          fl;
      bt   = 1'($urandom_range(0, 1));
      c    = 3'($urandom_range(0, 7));
      pend = 1'($urandom_range(0, 1));
      haz  = pend && (c != 3'b111);
      fl   = ($urandom_range(0, 7) == 0) ? (haz ? 2 : 1) : 0;
      branch(bt, c, 16'($urandom), 9'($urandom), 16'($urandom),
             3'($urandom), 3'($urandom), pend, fl);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end

    idle(3);
    chk("scoreboard_empty", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
